// File: rtl/uart_cmd_sequencer.sv
// Expands one register-file / ALU command into its frame-protocol byte sequence
// and serializes each byte as a UART frame (start, 8 data LSB-first, optional parity, stop).
module uart_cmd_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_type,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [DATA_WIDTH-1:0] cmd_op_a,
    input  logic [DATA_WIDTH-1:0] cmd_op_b,
    input  logic [3:0]            cmd_alu_fun,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic [DIV_WIDTH-1:0]  div_ratio,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q;
    logic [1:0]            type_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [3:0]            fun_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic [BW-1:0]         bit_q;
    logic [1:0]            byte_idx_q;
    logic                  tx_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] cur_byte;
    logic [1:0]            last_byte;
    logic [BW-1:0]         bit_next;
    logic                  parity_bit;
    logic                  last_tick;

    // Byte currently on the line, selected from the captured command fields.
    always_comb begin
        cur_byte  = '0;
        last_byte = 2'd1;
        case (type_q)
            2'd0: begin
                last_byte = 2'd2;
                case (byte_idx_q)
                    2'd0:    cur_byte = DATA_WIDTH'(8'hAA);
                    2'd1:    cur_byte = DATA_WIDTH'(addr_q);
                    default: cur_byte = data_q;
                endcase
            end
            2'd1: cur_byte = (byte_idx_q == 2'd0) ? DATA_WIDTH'(8'hBB) : DATA_WIDTH'(addr_q);
            2'd2: begin
                last_byte = 2'd3;
                case (byte_idx_q)
                    2'd0:    cur_byte = DATA_WIDTH'(8'hCC);
                    2'd1:    cur_byte = op_a_q;
                    2'd2:    cur_byte = op_b_q;
                    default: cur_byte = DATA_WIDTH'(fun_q);
                endcase
            end
            default: cur_byte = (byte_idx_q == 2'd0) ? DATA_WIDTH'(8'hDD) : DATA_WIDTH'(fun_q);
        endcase
    end

    assign bit_next   = bit_q + BW'(1);
    assign parity_bit = (^cur_byte) ^ par_type_q;
    assign last_tick  = (cnt_q == div_q - DIV_WIDTH'(1));

    // div_q holds the already-clamped bit period so a zero ratio behaves as one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        type_q     <= cmd_type;
                        addr_q     <= cmd_addr;
                        data_q     <= cmd_data;
                        op_a_q     <= cmd_op_a;
                        op_b_q     <= cmd_op_b;
                        fun_q      <= cmd_alu_fun;
                        par_en_q   <= par_en;
                        par_type_q <= par_type;
                        div_q      <= (div_ratio == '0) ? DIV_WIDTH'(1) : div_ratio;
                        cnt_q      <= '0;
                        bit_q      <= '0;
                        byte_idx_q <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= START;
                    end
                end
                START: begin
                    if (last_tick) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= cur_byte[0];
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        cnt_q <= '0;
                        if (bit_q == BW'(DATA_WIDTH - 1)) begin
                            bit_q <= '0;
                            if (par_en_q) begin
                                tx_q    <= parity_bit;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q <= bit_next;
                            tx_q  <= cur_byte[bit_next];
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (last_tick) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    // Next byte's start bit follows the stop bit with no idle gap.
                    if (last_tick) begin
                        cnt_q <= '0;
                        if (byte_idx_q == last_byte) begin
                            tx_q    <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_WIDTH'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_out     = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE);
    assign cmd_ready  = (state_q == IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: table vectors, reset and back-to-back
// sequences, and random commands checked against a cycle-level waveform model.
module tb_uart_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_type;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [7:0] cmd_op_a;
    logic [7:0] cmd_op_b;
    logic [3:0] cmd_alu_fun;
    logic       par_en;
    logic       par_type;
    logic [7:0] div_ratio;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] typ;
        logic [3:0] addr;
        logic [7:0] data;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] fun;
        logic       pen;
        logic       ptype;
        logic [7:0] div;
    } cmd_t;

    typedef struct {
        cmd_t        c;
        int          expT;
        logic [31:0] expBytes;
        logic [3:0]  expPar;
    } vec_t;

    logic expQ[$];
    logic seen[$];
    int   busyCount;
    vec_t vecs[4];

    uart_cmd_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DIV_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_type    (cmd_type),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_op_a    (cmd_op_a),
        .cmd_op_b    (cmd_op_b),
        .cmd_alu_fun (cmd_alu_fun),
        .par_en      (par_en),
        .par_type    (par_type),
        .div_ratio   (div_ratio),
        .tx_out      (tx_out),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    function automatic cmd_t mkCmd(input logic [1:0] typ, input logic [3:0] addr,
                                   input logic [7:0] data, input logic [7:0] opa,
                                   input logic [7:0] opb, input logic [3:0] fun,
                                   input logic pen, input logic ptype, input logic [7:0] div);
        cmd_t c;
        c.typ = typ; c.addr = addr; c.data = data; c.opa = opa; c.opb = opb;
        c.fun = fun; c.pen = pen; c.ptype = ptype; c.div = div;
        return c;
    endfunction

    function automatic int effR(input cmd_t c);
        return (c.div == 8'd0) ? 1 : int'(c.div);
    endfunction

    function automatic void pushBit(input logic v, input int r);
        for (int k = 0; k < r; k++) expQ.push_back(v);
    endfunction

    // Reference: expected line level for every cycle of the command, built from the byte list.
    function automatic void buildWave(input cmd_t c);
        logic [7:0] bytes[$];
        logic [7:0] b;
        int r;
        r = effR(c);
        bytes.delete();
        case (c.typ)
            2'd0: begin bytes.push_back(8'hAA); bytes.push_back({4'h0, c.addr}); bytes.push_back(c.data); end
            2'd1: begin bytes.push_back(8'hBB); bytes.push_back({4'h0, c.addr}); end
            2'd2: begin bytes.push_back(8'hCC); bytes.push_back(c.opa); bytes.push_back(c.opb); bytes.push_back({4'h0, c.fun}); end
            default: begin bytes.push_back(8'hDD); bytes.push_back({4'h0, c.fun}); end
        endcase
        expQ.delete();
        foreach (bytes[i]) begin
            b = bytes[i];
            pushBit(1'b0, r);
            for (int k = 0; k < 8; k++) pushBit(b[k], r);
            if (c.pen) pushBit((^b) ^ c.ptype, r);
            pushBit(1'b1, r);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic driveCmd(input cmd_t c);
        cmd_type    = c.typ;
        cmd_addr    = c.addr;
        cmd_data    = c.data;
        cmd_op_a    = c.opa;
        cmd_op_b    = c.opb;
        cmd_alu_fun = c.fun;
        par_en      = c.pen;
        par_type    = c.ptype;
        div_ratio   = c.div;
    endtask

    // Called at a negedge with the block idle; the command is accepted on the next posedge.
    // With holdNext the next command is presented immediately and div_ratio wiggles mid-command.
    task automatic applyStimulus(input cmd_t c, input bit holdNext, input cmd_t nxt);
        int t;
        checkOutput("ready_before_cmd", 32'(cmd_ready), 32'd1);
        driveCmd(c);
        cmd_valid = 1'b1;
        buildWave(c);
        t = expQ.size();
        seen.delete();
        busyCount = 0;
        for (int i = 0; i < t; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (holdNext) begin
                    driveCmd(nxt);
                    div_ratio = nxt.div + 8'd3;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (holdNext && i == t / 2) div_ratio = nxt.div;
            seen.push_back(tx_out);
            if (busy) busyCount++;
            checkOutput("tx_line", 32'(tx_out), 32'(expQ[i]));
            checkOutput("busy_in_cmd", 32'(busy), 32'd1);
            checkOutput("ready_in_cmd", 32'(cmd_ready), 32'd0);
            checkOutput("done_in_cmd", 32'(frame_done), 32'd0);
        end
        @(negedge clk);
        checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
        checkOutput("ready_after_cmd", 32'(cmd_ready), 32'd1);
        checkOutput("tx_idle_after_cmd", 32'(tx_out), 32'd1);
        checkOutput("busy_after_cmd", 32'(busy), 32'd0);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("idle_tx", 32'(tx_out), 32'd1);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_done", 32'(frame_done), 32'd0);
        end
    endtask

    // Main sequence: reset, table vectors, reset abort, back-to-back, random commands.
    initial begin
        cmd_t c, d, none;
        int r, bl, nb, idx;
        logic [7:0] got;

        none = mkCmd(2'd0, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'd1);
        vecs[0] = '{c: mkCmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'd1),
                    expT: 30, expBytes: 32'h003C05AA, expPar: 4'b0000};
        vecs[1] = '{c: mkCmd(2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'd4),
                    expT: 88, expBytes: 32'h00000ABB, expPar: 4'b0000};
        vecs[2] = '{c: mkCmd(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h0, 1'b1, 1'b1, 8'd2),
                    expT: 88, expBytes: 32'h003412CC, expPar: 4'b1011};
        vecs[3] = '{c: mkCmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h3, 1'b0, 1'b0, 8'd0),
                    expT: 20, expBytes: 32'h000003DD, expPar: 4'b0000};

        rst = 1'b1;
        cmd_valid = 1'b0;
        driveCmd(none);
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx_out), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(frame_done), 32'd0);
        checkOutput("reset_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        idleCycles(2);

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].c, 1'b0, none);
            checkOutput("table_busy_cycles", 32'(busyCount), 32'(vecs[v].expT));
            r  = effR(vecs[v].c);
            bl = (vecs[v].c.pen ? 11 : 10) * r;
            nb = vecs[v].expT / bl;
            for (int b = 0; b < nb; b++) begin
                got = 8'h00;
                for (int k = 0; k < 8; k++) begin
                    idx = b * bl + (1 + k) * r;
                    if (idx < seen.size()) got[k] = seen[idx];
                end
                checkOutput("table_byte", 32'(got), 32'(vecs[v].expBytes[b*8 +: 8]));
                if (vecs[v].c.pen) begin
                    idx = b * bl + 9 * r;
                    checkOutput("table_parity", (idx < seen.size()) ? 32'(seen[idx]) : 32'hFFFF,
                                32'(vecs[v].expPar[b]));
                end
            end
            idleCycles(2);
        end

        // Reset during data bit 1 of byte 1 of an RF_WR (R = 2, 20-cycle bytes).
        c = mkCmd(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'd2);
        driveCmd(c);
        cmd_valid = 1'b1;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
        end
        checkOutput("abort_busy_before", 32'(busy), 32'd1);
        checkOutput("abort_tx_before", 32'(tx_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_tx", 32'(tx_out), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ready", 32'(cmd_ready), 32'd1);
        checkOutput("abort_done", 32'(frame_done), 32'd0);
        idleCycles(5);
        applyStimulus(mkCmd(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 8'd1), 1'b0, none);
        idleCycles(1);

        // Back-to-back with valid held and div_ratio changed while the first command runs.
        c = mkCmd(2'd0, 4'h9, 8'hA5, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'd3);
        d = mkCmd(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h7, 1'b0, 1'b0, 8'd1);
        applyStimulus(c, 1'b1, d);
        applyStimulus(d, 1'b0, none);
        idleCycles(2);

        for (int n = 0; n < 20; n++) begin
            c = mkCmd(2'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                      8'($urandom_range(0, 4)));
            applyStimulus(c, 1'b0, none);
            idleCycles(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
